gate_vector_checker: RTL and testbench

//   Synthesizable self-checking exerciser for a 2-input combinational gate under test.
//   It drives the gate inputs a,b through the vectors 00,01,10,11. It samples the gate output y
//   and compares y against a parameterised truth table. It reports the pass/fail count and the

---
 rtl/gate_chk_pkg.sv | 14 +
 rtl/gate_vector_checker_if.sv | 16 +
 rtl/gate_vector_checker_settle_timer.sv | 23 ++
 rtl/gate_vector_checker.sv | 75 +++++++
 tb/tb_gate_vector_checker.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared FSM state type, gate truth-table constants and timer sizing helper
package gate_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam int NUM_VEC = 4;
  function automatic int tmr_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction
endpackage

// File: rtl/gate_vector_checker_if.sv
// gate_vector_checker_if: sweep control, gate drive/return and result signals
//   master drives start and y (bench / board wrapper); slave is the checker
interface gate_vector_checker_if;
  logic       start;
  logic       a;
  logic       b;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_count;
  logic       fail_seen;
  logic [1:0] first_fail_vec;
  modport master (output start, y, input a, b, busy, done, pass, fail_count, fail_seen, first_fail_vec);
  modport slave  (input start, y, output a, b, busy, done, pass, fail_count, fail_seen, first_fail_vec);
endinterface

// File: rtl/gate_vector_checker_settle_timer.sv
// settle_timer: counts 0..SETTLE-1 while en, tick marks the last cycle of each hold period
//   clk, rst: clock and sync active-high reset; clear: force count to 0; en: advance
//   tick: high while en and count==SETTLE-1; count: current hold-cycle index
module settle_timer
  import gate_chk_pkg::*;
#(
  parameter int SETTLE = 4,
  localparam int W = tmr_width(SETTLE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic         tick,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);
  assign tick = en && (count == LAST);
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (en) count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps a 2-input gate through 00..11, checks y against TRUTH, reports results
//   clk, rst: clock and sync active-high reset
//   io (slave): start in; a,b drive the gate; y returns from it; busy/done/pass/fail_count/
//   fail_seen/first_fail_vec report the sweep
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH = TT_AND,
  parameter int SETTLE = 4
) (
  input logic clk,
  input logic rst,
  gate_vector_checker_if.slave io
);
  localparam int TW = tmr_width(SETTLE);
  localparam logic [TW-1:0] LAST = TW'(SETTLE - 1);
  state_t state, state_n;
  logic [1:0] vec, vec_n, ffv, ffv_n;
  logic [2:0] fc, fc_n;
  logic fs, fs_n, pass, pass_n, tick, sample, mismatch;
  logic [TW-1:0] tmr;
  settle_timer #(.SETTLE(SETTLE)) u_tmr (
    .clk, .rst, .clear(state != RUN), .en(state == RUN), .tick, .count(tmr)
  );
  assign sample = tick && (tmr == LAST);
  assign mismatch = sample && (io.y != TRUTH[vec]);
  always_comb begin
    state_n = state;
    vec_n = vec;
    fc_n = fc;
    fs_n = fs;
    ffv_n = ffv;
    pass_n = pass;
    if (state != RUN && io.start) begin
      state_n = RUN;
      vec_n = '0;
      fc_n = '0;
      fs_n = 1'b0;
      ffv_n = '0;
      pass_n = 1'b0;
    end else if (state == RUN && sample) begin
      fc_n = fc + 3'(mismatch);
      fs_n = fs || mismatch;
      ffv_n = (mismatch && !fs) ? vec : ffv;
      vec_n = (vec == 2'(NUM_VEC - 1)) ? 2'd0 : vec + 2'd1;
      state_n = (vec == 2'(NUM_VEC - 1)) ? DONE : RUN;
      pass_n = (vec == 2'(NUM_VEC - 1)) ? (fc_n == 3'd0) : pass;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      fc <= '0;
      fs <= 1'b0;
      ffv <= '0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      vec <= vec_n;
      fc <= fc_n;
      fs <= fs_n;
      ffv <= ffv_n;
      pass <= pass_n;
    end
  end
  // vec returns to 0 on completion, so a,b idle low outside a sweep
  assign {io.a, io.b} = vec;
  assign io.busy = (state == RUN);
  assign io.done = (state == DONE);
  assign io.pass = pass;
  assign io.fail_count = fc;
  assign io.fail_seen = fs;
  assign io.first_fail_vec = ffv;
endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: scoreboard bench for gate_vector_checker (AND/SETTLE=4 and XOR/SETTLE=1)
module tb_gate_vector_checker;
  import gate_chk_pkg::*;
  typedef struct {
    logic       pass;
    logic [2:0] fc;
    logic       fs;
    logic [1:0] ffv;
    int         cycles;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  int mode = 0;
  int checks = 0;
  int passes = 0;
  exp_t sb[$];
  logic [10:0] obs, obs1, obs2;
  always #5 clk = ~clk;
  gate_vector_checker_if b1 ();
  gate_vector_checker_if b2 ();
  gate_vector_checker #(.TRUTH(TT_AND), .SETTLE(4)) dut1 (.clk(clk), .rst(rst), .io(b1.slave));
  gate_vector_checker #(.TRUTH(TT_XOR), .SETTLE(1)) dut2 (.clk(clk), .rst(rst), .io(b2.slave));
  function automatic logic gate(input int m, input logic a, input logic b);
    return m == 0 ? (a & b) : m == 1 ? (a | b) : m == 2 ? 1'b1 : m == 3 ? 1'b0 : (a ^ b);
  endfunction
  assign b1.start = start && !sel;
  assign b2.start = start && sel;
  assign b1.y = gate(mode, b1.a, b1.b);
  assign b2.y = gate(mode, b2.a, b2.b);
  assign obs1 = {b1.a, b1.b, b1.busy, b1.done, b1.pass, b1.fail_count, b1.fail_seen, b1.first_fail_vec};
  assign obs2 = {b2.a, b2.b, b2.busy, b2.done, b2.pass, b2.fail_count, b2.fail_seen, b2.first_fail_vec};
  assign obs = sel ? obs2 : obs1;
  function automatic exp_t model();
    exp_t e;
    logic [3:0] truth;
    logic [1:0] v;
    truth = sel ? TT_XOR : TT_AND;
    e.cycles = sel ? 4 : 16;
    e.fc = 3'd0;
    e.fs = 1'b0;
    e.ffv = 2'd0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (gate(mode, v[1], v[0]) != truth[v]) begin
        if (!e.fs) e.ffv = v;
        e.fs = 1'b1;
        e.fc = e.fc + 3'd1;
      end
    end
    e.pass = (e.fc == 3'd0);
    return e;
  endfunction
  task automatic sweep(input string name, input int pulse_at, input int rst_at);
    exp_t e;
    int n;
    int st;
    logic [1:0] ev;
    st = sel ? 1 : 4;
    sb.push_back(model());
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({obs[8:7], obs[5:2]} !== 6'b10_0000) $display("FAIL %s start: busy,done,fc,fs=%b required 100000", name, {obs[8:7], obs[5:2]});
    else passes++;
    n = 1;
    while (obs[8] && n <= 64) begin
      ev = 2'((n - 1) / st);
      checks++;
      if (obs[10:9] !== ev) $display("FAIL %s vec@%0d: ab=%b required %b", name, n, obs[10:9], ev);
      else passes++;
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checks++;
        if (obs !== 11'd0) $display("FAIL %s reset: outputs=%b required 0", name, obs);
        else passes++;
        void'(sb.pop_back());
        return;
      end
      start = (n == pulse_at);
      @(negedge clk) start = 1'b0;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (n - 1 !== e.cycles) $display("FAIL %s busy_cycles: got %0d required %0d", name, n - 1, e.cycles);
    else passes++;
    checks++;
    if ({obs[10:7]} !== 4'b0001) $display("FAIL %s done_state: a,b,busy,done=%b required 0001", name, obs[10:7]);
    else passes++;
    checks++;
    if (obs[6] !== e.pass) $display("FAIL %s pass: got %b required %b", name, obs[6], e.pass);
    else passes++;
    checks++;
    if (obs[5:3] !== e.fc) $display("FAIL %s fail_count: got %0d required %0d", name, obs[5:3], e.fc);
    else passes++;
    checks++;
    if (obs[2:0] !== {e.fs, e.ffv}) $display("FAIL %s first_fail: fs,vec=%b required %b", name, obs[2:0], {e.fs, e.ffv});
    else passes++;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({obs1, obs2} !== 22'd0) $display("FAIL reset_state: got %b required 0", {obs1, obs2});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_gates();
    mode = 0; sweep("and_pass", 0, 0);
    mode = 1; sweep("or_dut", 0, 0);
    mode = 2; sweep("y_one", 0, 0);
    mode = 3; sweep("y_zero", 0, 0);
  endtask
  task automatic test_start_ignored();
    mode = 0; sweep("start_mid", 5, 0);
  endtask
  task automatic test_back_to_back();
    mode = 1; sweep("restart_a", 0, 0);
    mode = 0; sweep("restart_b", 0, 0);
    mode = 0; sweep("restart_c", 0, 0);
  endtask
  task automatic test_mid_reset();
    mode = 0; sweep("mid_reset", 0, 6);
    @(negedge clk);
    checks++;
    if (obs1 !== 11'd0) $display("FAIL idle_after_reset: got %b required 0", obs1);
    else passes++;
    mode = 1; sweep("after_reset", 0, 0);
  endtask
  task automatic test_settle1();
    sel = 1'b1;
    mode = 4; sweep("xor_s1", 0, 0);
    mode = 0; sweep("xor_s1_and", 0, 0);
    sel = 1'b0;
  endtask
  initial begin
    test_reset();
    test_gates();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_settle1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
